l2_scrub_ctrl: RTL



---
 rtl/carfield_pkg.sv | 18 +
 rtl/l2_scrub_sat_cnt.sv | 42 ++++
 rtl/l2_scrub_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/carfield_pkg.sv
// Shared types and default constants for the L2 background scrubber.
package carfield_pkg;

    // Default geometry of the L2 scrub port.
    localparam int unsigned L2ScrubAddrWidth     = 20;
    localparam int unsigned L2ScrubWordBytes     = 8;
    localparam int unsigned L2ScrubIntervalWidth = 16;
    localparam int unsigned L2ScrubCntWidth      = 16;

    // Scrubber sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        REQ  = 2'd2,
        RESP = 2'd3
    } scrub_state_e;

endpackage

// File: rtl/l2_scrub_sat_cnt.sv
// Saturating event counter with synchronous clear; an increment in the
// same cycle as a clear leaves the counter at one.
module l2_scrub_sat_cnt
    import carfield_pkg::*;
#(
    parameter int unsigned Width = L2ScrubCntWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Next count: an increment beats a clear, and the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            if (clr_i) begin
                cnt_d = Width'(1);
            end else if (cnt_q != {Width{1'b1}}) begin
                cnt_d = cnt_q + Width'(1);
            end
        end else if (clr_i) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/l2_scrub_ctrl.sv
// Background ECC scrubber for L2: walks a word-aligned address window one
// read at a time, yields to host traffic, counts corrected/uncorrectable
// errors and latches the address of the last uncorrectable one.
module l2_scrub_ctrl
    import carfield_pkg::*;
#(
    parameter int unsigned AddrWidth     = L2ScrubAddrWidth,
    parameter int unsigned WordBytes     = L2ScrubWordBytes,
    parameter int unsigned IntervalWidth = L2ScrubIntervalWidth,
    parameter int unsigned CntWidth      = L2ScrubCntWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [AddrWidth-1:0]     start_addr_i,
    input  logic [AddrWidth-1:0]     end_addr_i,
    input  logic [IntervalWidth-1:0] interval_i,
    input  logic                     host_busy_i,
    input  logic                     clr_i,
    output logic                     scrub_req_o,
    output logic [AddrWidth-1:0]     scrub_addr_o,
    input  logic                     scrub_gnt_i,
    input  logic                     scrub_rvalid_i,
    input  logic                     scrub_corr_i,
    input  logic                     scrub_uncorr_i,
    output logic                     busy_o,
    output logic                     pass_done_o,
    output logic [CntWidth-1:0]      corr_cnt_o,
    output logic [CntWidth-1:0]      uncorr_cnt_o,
    output logic [AddrWidth-1:0]     err_addr_o,
    output logic                     err_irq_o
);

    scrub_state_e             state_q, state_d;
    logic [AddrWidth-1:0]     ptr_q, ptr_d;
    logic [IntervalWidth-1:0] ival_q, ival_d;
    logic                     pass_done_q, pass_done_d;
    logic [AddrWidth-1:0]     err_addr_q, err_addr_d;
    logic                     err_irq_q, err_irq_d;

    logic rsp_fire;
    logic corr_evt;
    logic uncorr_evt;
    logic last_word;

    // A response only counts while a read is actually outstanding, so a
    // stray rvalid after reset or in any other state is dropped.
    assign rsp_fire   = (state_q == RESP) && scrub_rvalid_i;
    assign uncorr_evt = rsp_fire && scrub_uncorr_i;
    assign corr_evt   = rsp_fire && scrub_corr_i && !scrub_uncorr_i;
    // An inverted window collapses to the single word at the start address.
    assign last_word  = (ptr_q == end_addr_i) || (start_addr_i > end_addr_i);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a disable only takes effect once no read is in flight.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en_i) state_d = WAIT;
            end
            WAIT: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if ((ival_q == '0) && !host_busy_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (scrub_gnt_i && !host_busy_i) state_d = RESP;
            end
            RESP: begin
                if (scrub_rvalid_i) state_d = en_i ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; the request drops immediately whenever the host needs the port.
    always_comb begin
        busy_o       = (state_q != IDLE);
        scrub_req_o  = (state_q == REQ) && !host_busy_i;
        scrub_addr_o = ptr_q;
    end

    // Pointer, idle-gap counter, pass marker and error capture next values.
    always_comb begin
        ptr_d       = ptr_q;
        ival_d      = ival_q;
        pass_done_d = 1'b0;
        err_addr_d  = err_addr_q;
        err_irq_d   = err_irq_q;

        if ((state_q == IDLE) && en_i) begin
            ptr_d  = start_addr_i;
            ival_d = interval_i;
        end

        if ((state_q == WAIT) && (ival_q != '0)) begin
            ival_d = ival_q - IntervalWidth'(1);
        end

        if (rsp_fire) begin
            ival_d      = interval_i;
            pass_done_d = last_word;
            ptr_d       = last_word ? start_addr_i : (ptr_q + AddrWidth'(WordBytes));
        end

        if (uncorr_evt) begin
            err_addr_d = ptr_q;
            err_irq_d  = 1'b1;
        end else if (clr_i) begin
            err_addr_d = '0;
            err_irq_d  = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            ival_q      <= '0;
            pass_done_q <= 1'b0;
            err_addr_q  <= '0;
            err_irq_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            ival_q      <= ival_d;
            pass_done_q <= pass_done_d;
            err_addr_q  <= err_addr_d;
            err_irq_q   <= err_irq_d;
        end
    end

    assign pass_done_o = pass_done_q;
    assign err_addr_o  = err_addr_q;
    assign err_irq_o   = err_irq_q;

    l2_scrub_sat_cnt #(
        .Width (CntWidth)
    ) u_corr_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .inc_i (corr_evt),
        .cnt_o (corr_cnt_o)
    );

    l2_scrub_sat_cnt #(
        .Width (CntWidth)
    ) u_uncorr_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .inc_i (uncorr_evt),
        .cnt_o (uncorr_cnt_o)
    );

endmodule
